// File: rtl/snoop_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : snoop_bus_arbiter
// Purpose  : Round-robin arbiter and sequencer for the shared MESI snoop bus
//            between NUM_REQ L1 controllers and the L2. Grants the bus to one
//            L1 at a time, holds it until completion (bus_valid), withdrawal
//            (req drop) or timeout, then inserts one dead turnaround cycle.
// Ports    : clk          - single clock, rising edge
//            reset_n      - asynchronous active-low reset
//            req          - per-L1 level request
//            bus_valid    - sampled BusValid (completion); X/Z act as 0
//            gnt          - registered one-hot grant
//            bus_busy     - BusBusy, high exactly when gnt is nonzero
//            owner        - index of current or most recent grantee
//            timeout_err  - one-cycle pulse during a forced release
//            txn_count    - saturating count of completed transactions
// Revision : 1.0 - initial release
// ============================================================================
module snoop_bus_arbiter #(
  parameter int          NUM_REQ         = 4,
  parameter int          TIMEOUT         = 64,
  // Reset value of txn_count; 0 in normal use, nonzero only for bring-up
  // preload of the saturating counter.
  parameter logic [15:0] TXN_COUNT_RESET = 16'h0000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       bus_valid,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       bus_busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       timeout_err,
  output logic [15:0]                txn_count
);

  localparam int                   OWNER_W    = $clog2(NUM_REQ);
  localparam int                   WAIT_W     = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0]    WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam logic [OWNER_W-1:0]   LAST_RESET = OWNER_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]   GNT_ONE    = NUM_REQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t               state_q,       state_d;
  logic [NUM_REQ-1:0]   gnt_q,         gnt_d;
  logic                 bus_busy_q,    bus_busy_d;
  logic [OWNER_W-1:0]   owner_q,       owner_d;
  logic [OWNER_W-1:0]   last_q,        last_d;
  logic [WAIT_W-1:0]    wait_cnt_q,    wait_cnt_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [15:0]          txn_count_q,   txn_count_d;

  logic [OWNER_W-1:0]   winner;
  logic                 req_any;
  logic                 completed;

  assign req_any = |req;
  // Only a clean 1 counts as completion; an unknown value falls through
  // to the other rules.
  assign completed = (bus_valid == 1'b1);

  // Round-robin pick: the requester at the smallest offset 1..NUM_REQ after
  // last wins. Offsets are scanned from largest to smallest so the final
  // matching assignment is the closest one.
  always_comb begin
    winner = last_q;
    for (int i = NUM_REQ; i >= 1; i--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req[j] && (((int'(last_q) + i) % NUM_REQ) == j)) begin
          winner = OWNER_W'(j);
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    owner_d       = owner_q;
    last_d        = last_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = 1'b0;
    txn_count_d   = txn_count_q;

    case (state_q)
      // The turnaround cycle arbitrates exactly like IDLE, so a pending
      // request goes straight back to OWN after one dead cycle.
      ST_IDLE, ST_RELEASE: begin
        if (req_any) begin
          state_d    = ST_OWN;
          gnt_d      = GNT_ONE << winner;
          owner_d    = winner;
          last_d     = winner;
          wait_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end

      ST_OWN: begin
        if (completed) begin
          state_d     = ST_RELEASE;
          gnt_d       = '0;
          txn_count_d = (txn_count_q == 16'hFFFF) ? txn_count_q
                                                  : txn_count_q + 16'd1;
        end else if (!req[owner_q]) begin
          state_d = ST_RELEASE;
          gnt_d   = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d       = ST_RELEASE;
          gnt_d         = '0;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    bus_busy_d = |gnt_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      gnt_q         <= '0;
      bus_busy_q    <= 1'b0;
      owner_q       <= '0;
      last_q        <= LAST_RESET;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      txn_count_q   <= TXN_COUNT_RESET;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      bus_busy_q    <= bus_busy_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
      txn_count_q   <= txn_count_d;
    end
  end

  assign gnt         = gnt_q;
  assign bus_busy    = bus_busy_q;
  assign owner       = owner_q;
  assign timeout_err = timeout_err_q;
  assign txn_count   = txn_count_q;

endmodule
`default_nettype wire

// File: tb/tb_snoop_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_snoop_bus_arbiter
// Purpose  : Self-checking bench for snoop_bus_arbiter: vector table,
//            randomized run against a behavioural model, and hand-written
//            corner sequences (timeout, withdrawal, collision, async reset,
//            X on bus_valid, counter saturation).
// Revision : 1.0 - initial release
// ============================================================================
module tb_snoop_bus_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req,  req2;
  logic        bus_valid, bus_valid2;
  logic [3:0]  gnt,  gnt2;
  logic        bus_busy, bus_busy2;
  logic [1:0]  owner, owner2;
  logic        timeout_err, timeout_err2;
  logic [15:0] txn_count, txn_count2;

  always #5 clk = ~clk;

  snoop_bus_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .bus_valid(bus_valid),
    .gnt(gnt), .bus_busy(bus_busy), .owner(owner),
    .timeout_err(timeout_err), .txn_count(txn_count)
  );

  snoop_bus_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .TXN_COUNT_RESET(16'hFFFE)) dut_sat (
    .clk(clk), .reset_n(reset_n), .req(req2), .bus_valid(bus_valid2),
    .gnt(gnt2), .bus_busy(bus_busy2), .owner(owner2),
    .timeout_err(timeout_err2), .txn_count(txn_count2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_all(input string name, input logic [3:0] g, input logic b,
                            input logic [1:0] o, input logic t, input logic [15:0] c);
    check({name, ".gnt"},         32'(gnt),         32'(g));
    check({name, ".bus_busy"},    32'(bus_busy),    32'(b));
    check({name, ".owner"},       32'(owner),       32'(o));
    check({name, ".timeout_err"}, 32'(timeout_err), 32'(t));
    check({name, ".txn_count"},   32'(txn_count),   32'(c));
  endtask

  // ---------------- behavioural model ----------------
  // m_own: index currently holding the bus, -1 when nobody does.
  // m_age: number of cycles the current owner has held the bus so far.
  int m_own, m_last, m_shown, m_age, m_cnt;
  bit m_tout;

  task automatic model_reset();
    m_own = -1; m_last = N - 1; m_shown = 0; m_age = 0; m_cnt = 0; m_tout = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic bv);
    int w;
    m_tout = 1'b0;
    if (m_own >= 0) begin
      if (bv === 1'b1) begin
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        m_own = -1;
      end else if (((r >> m_own) & 4'd1) == 4'd0) begin
        m_own = -1;
      end else if (m_age == TO) begin
        m_tout = 1'b1;
        m_own  = -1;
      end else begin
        m_age++;
      end
    end else begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (w < 0 && ((r >> c) & 4'd1) != 4'd0) w = c;
      end
      if (w >= 0) begin
        m_own = w; m_last = w; m_shown = w; m_age = 1;
      end
    end
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic cycle(input logic [3:0] r, input logic bv);
    req = r; bus_valid = bv;
    @(posedge clk);
    model_step(r, bv);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = '0; bus_valid = 1'b0; req2 = '0; bus_valid2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst;
    logic [3:0]  req;
    logic        bv;
    logic [3:0]  g;
    logic        b;
    logic [1:0]  o;
    logic        t;
    logic [15:0] c;
  } vec_t;

  vec_t tbl [0:17];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [3:0] r;
    logic       bv;

    // single request
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0, 16'd0};
    tbl[3]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0, 16'd0};
    tbl[4]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 16'd1};
    tbl[5]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 16'd1};
    // fairness: all four requesting, one-cycle ownerships
    tbl[6]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 16'd0};
    tbl[7]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 16'd0};
    tbl[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'd1};
    tbl[9]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 16'd1};
    tbl[10] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 16'd2};
    tbl[11] = '{1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0, 16'd2};
    tbl[12] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 16'd3};
    tbl[13] = '{1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0, 16'd3};
    tbl[14] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0, 16'd4};
    tbl[15] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 16'd4};
    tbl[16] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'd5};
    tbl[17] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 16'd5};

    reset_n = 1'b1; req = '0; bus_valid = 1'b0; req2 = '0; bus_valid2 = 1'b0;
    #1;

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].rst) do_reset();
      else            cycle(tbl[i].req, tbl[i].bv);
      expect_all($sformatf("vec%0d", i), tbl[i].g, tbl[i].b, tbl[i].o, tbl[i].t, tbl[i].c);
    end

    // ---------------- randomized run against the model ----------------
    do_reset();
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) r = 4'($urandom_range(0, 15));
      bv = ($urandom_range(0, 7) == 0);
      cycle(r, bv);
      expect_all("rand", (m_own >= 0) ? 4'(1 << m_own) : 4'd0, (m_own >= 0),
                 2'(m_shown), m_tout, 16'(m_cnt));
    end

    // ---------------- timeout with a second requester waiting ----------------
    do_reset();
    cycle(4'b0011, 1'b0);
    expect_all("to.grant", 4'b0001, 1'b1, 2'd0, 1'b0, 16'd0);
    for (int i = 0; i < 7; i++) begin
      cycle(4'b0011, 1'b0);
      expect_all("to.hold", 4'b0001, 1'b1, 2'd0, 1'b0, 16'd0);
    end
    cycle(4'b0011, 1'b0);
    expect_all("to.release", 4'b0000, 1'b0, 2'd0, 1'b1, 16'd0);
    cycle(4'b0011, 1'b0);
    expect_all("to.next", 4'b0010, 1'b1, 2'd1, 1'b0, 16'd0);

    // ---------------- withdrawal by owner 1 ----------------
    cycle(4'b0011, 1'b0);
    expect_all("wd.hold", 4'b0010, 1'b1, 2'd1, 1'b0, 16'd0);
    cycle(4'b0001, 1'b0);
    expect_all("wd.release", 4'b0000, 1'b0, 2'd1, 1'b0, 16'd0);
    cycle(4'b0001, 1'b0);
    expect_all("wd.regrant", 4'b0001, 1'b1, 2'd0, 1'b0, 16'd0);

    // ---------------- lone requester times out and is re-granted ----------------
    for (int i = 0; i < 7; i++) cycle(4'b0001, 1'b0);
    cycle(4'b0001, 1'b0);
    expect_all("to0.release", 4'b0000, 1'b0, 2'd0, 1'b1, 16'd0);
    cycle(4'b0001, 1'b0);
    expect_all("to0.back", 4'b0001, 1'b1, 2'd0, 1'b0, 16'd0);
    cycle(4'b0001, 1'b1);
    expect_all("to0.done", 4'b0000, 1'b0, 2'd0, 1'b0, 16'd1);

    // ---------------- completion + withdrawal + timeout on one edge ----------------
    cycle(4'b0100, 1'b0);
    expect_all("col3.grant", 4'b0100, 1'b1, 2'd2, 1'b0, 16'd1);
    for (int i = 0; i < 7; i++) cycle(4'b0100, 1'b0);
    expect_all("col3.last", 4'b0100, 1'b1, 2'd2, 1'b0, 16'd1);
    cycle(4'b0000, 1'b1);
    expect_all("col3.release", 4'b0000, 1'b0, 2'd2, 1'b0, 16'd2);

    // ---------------- completion and withdrawal on one edge ----------------
    cycle(4'b0010, 1'b0);
    expect_all("col2.grant", 4'b0010, 1'b1, 2'd1, 1'b0, 16'd2);
    cycle(4'b0000, 1'b1);
    expect_all("col2.release", 4'b0000, 1'b0, 2'd1, 1'b0, 16'd3);

    // ---------------- X on bus_valid is not a completion ----------------
    cycle(4'b1000, 1'b0);
    expect_all("x.grant", 4'b1000, 1'b1, 2'd3, 1'b0, 16'd3);
    cycle(4'b1000, 1'bx);
    expect_all("x.hold1", 4'b1000, 1'b1, 2'd3, 1'b0, 16'd3);
    cycle(4'b1000, 1'bx);
    expect_all("x.hold2", 4'b1000, 1'b1, 2'd3, 1'b0, 16'd3);
    bus_valid = 1'b0;

    // ---------------- asynchronous reset between edges ----------------
    #2;
    reset_n = 1'b0;
    #1;
    check("arst.gnt",       32'(gnt),       32'd0);
    check("arst.bus_busy",  32'(bus_busy),  32'd0);
    check("arst.txn_count", 32'(txn_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    cycle(4'b1001, 1'b0);
    expect_all("arst.grant", 4'b0001, 1'b1, 2'd0, 1'b0, 16'd0);

    // ---------------- counter saturation (preloaded instance) ----------------
    do_reset();
    check("sat.reset", 32'(txn_count2), 32'h0000FFFE);
    for (int t = 0; t < 3; t++) begin
      req2 = 4'b0001; bus_valid2 = 1'b0;
      @(posedge clk); @(negedge clk);
      check($sformatf("sat.grant%0d", t), 32'(gnt2), 32'd1);
      bus_valid2 = 1'b1;
      @(posedge clk); @(negedge clk);
      check($sformatf("sat.gnt%0d", t),   32'(gnt2),         32'd0);
      check($sformatf("sat.count%0d", t), 32'(txn_count2),   32'h0000FFFF);
      check($sformatf("sat.tout%0d", t),  32'(timeout_err2), 32'd0);
    end
    req2 = '0; bus_valid2 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
